// File: rtl/decoder_pkg.sv
// Shared types and constants for the decoder_sweep block.
package decoder_pkg;

  localparam int MODE_ONEHOT = 0;
  localparam int MODE_THERMO = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

endpackage

// File: rtl/decoder_sweep_if.sv
// Request/select bundle between writeback control and the decoder_sweep block.
interface decoder_sweep_if #(
  parameter int ADDR_W = 5
);
  localparam int N = 1 << ADDR_W;

  logic              en;
  logic [ADDR_W-1:0] addr;
  logic              sweep_start;
  logic [N-1:0]      out;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output en, addr, sweep_start,
    input  out, busy, done, err
  );

  modport slave (
    input  en, addr, sweep_start,
    output out, busy, done, err
  );
endinterface

// File: rtl/decoder_comb.sv
// Combinational ADDR_W-to-2^ADDR_W decoder, one-hot or thermometer coded.
module decoder_comb
  import decoder_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int MODE   = MODE_ONEHOT
) (
  input  logic [ADDR_W-1:0]      a,
  output logic [(1<<ADDR_W)-1:0] y
);
  localparam int N = 1 << ADDR_W;

  always_comb begin
    y = '0;
    for (int i = 0; i < N; i++) begin
      if (MODE == MODE_THERMO) begin
        y[i] = (ADDR_W'(i) <= a);
      end else begin
        y[i] = (ADDR_W'(i) == a);
      end
    end
  end
endmodule

// File: rtl/decoder_sweep.sv
// Registered address decoder with a one-address-per-cycle sweep sequencer
// for clearing the register file after boot or on a flush.
module decoder_sweep
  import decoder_pkg::*;
#(
  parameter int ADDR_W    = 5,
  parameter int MODE      = MODE_ONEHOT,
  parameter int SKIP_ZERO = 1
) (
  input logic            clock,
  input logic            reset,
  decoder_sweep_if.slave bus
);
  localparam int N = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] FIRST = (SKIP_ZERO != 0) ? ADDR_W'(1) : '0;

  state_t            state_p1, state_nxt;
  logic [ADDR_W-1:0] cnt_p1, cnt_nxt;
  logic [N-1:0]      sel_p1, sel_nxt;
  logic              busy_p1, busy_nxt;
  logic              done_p1, done_nxt;
  logic              err_p1, err_nxt;

  logic [ADDR_W-1:0] dec_addr;
  logic              dec_en;
  logic [N-1:0]      dec_y;

  decoder_comb #(
    .ADDR_W (ADDR_W),
    .MODE   (MODE)
  ) u_dec (
    .a (dec_addr),
    .y (dec_y)
  );

  always_comb begin
    state_nxt = state_p1;
    cnt_nxt   = cnt_p1;
    dec_addr  = bus.addr;
    dec_en    = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    unique case (state_p1)
      IDLE: begin
        if (bus.sweep_start) begin
          // Sweep has priority; a simultaneous single decode is dropped.
          state_nxt = SWEEP;
          cnt_nxt   = FIRST;
          dec_addr  = FIRST;
          dec_en    = 1'b1;
          busy_nxt  = 1'b1;
          err_nxt   = bus.en;
        end else if (bus.en) begin
          dec_en = 1'b1;
        end
      end
      SWEEP: begin
        err_nxt = bus.en | bus.sweep_start;
        if (cnt_p1 == '1) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt  = cnt_p1 + 1'b1;
          dec_addr = cnt_p1 + 1'b1;
          dec_en   = 1'b1;
          busy_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    sel_nxt = dec_en ? dec_y : '0;
    if (SKIP_ZERO != 0) sel_nxt[0] = 1'b0;
  end

  // Output register stage: every output comes straight from a flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_p1 <= IDLE;
      cnt_p1   <= '0;
      sel_p1   <= '0;
      busy_p1  <= 1'b0;
      done_p1  <= 1'b0;
      err_p1   <= 1'b0;
    end else begin
      state_p1 <= state_nxt;
      cnt_p1   <= cnt_nxt;
      sel_p1   <= sel_nxt;
      busy_p1  <= busy_nxt;
      done_p1  <= done_nxt;
      err_p1   <= err_nxt;
    end
  end

  assign bus.out  = sel_p1;
  assign bus.busy = busy_p1;
  assign bus.done = done_p1;
  assign bus.err  = err_p1;
endmodule

// File: tb/tb_decoder_sweep.sv
// Scoreboard bench for decoder_sweep: one-hot/skip-zero and thermometer configs.
module tb_decoder_sweep;
  logic clk = 1'b0;
  logic rst5 = 1'b1;
  logic rst3 = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  decoder_sweep_if #(.ADDR_W(5)) if5 ();
  decoder_sweep_if #(.ADDR_W(3)) if3 ();

  decoder_sweep #(.ADDR_W(5), .MODE(0), .SKIP_ZERO(1)) dut5 (
    .clock (clk),
    .reset (rst5),
    .bus   (if5.slave)
  );

  decoder_sweep #(.ADDR_W(3), .MODE(1), .SKIP_ZERO(0)) dut3 (
    .clock (clk),
    .reset (rst3),
    .bus   (if3.slave)
  );

  typedef struct {
    int          cyc;
    logic [31:0] out;
    logic        busy;
    logic        done;
    logic        err;
    string       nm;
  } exp_t;

  exp_t q5[$];
  exp_t q3[$];

  task automatic check(input exp_t e, input logic [31:0] o, input logic b,
                       input logic d, input logic er);
    n_tests++;
    if (o !== e.out || b !== e.busy || d !== e.done || er !== e.err) begin
      n_fail++;
      $display("FAIL %s @cyc%0d: got out=%h busy=%b done=%b err=%b, want out=%h busy=%b done=%b err=%b",
               e.nm, e.cyc, o, b, d, er, e.out, e.busy, e.done, e.err);
    end
  endtask

  always @(negedge clk) begin
    while (q5.size() > 0 && q5[0].cyc <= cyc) begin
      exp_t e;
      e = q5.pop_front();
      check(e, if5.out, if5.busy, if5.done, if5.err);
    end
  end

  always @(negedge clk) begin
    while (q3.size() > 0 && q3[0].cyc <= cyc) begin
      exp_t e;
      e = q3.pop_front();
      check(e, {24'b0, if3.out}, if3.busy, if3.done, if3.err);
    end
  end

  // Drive one cycle on the selected DUT and queue what it must show next cycle;
  // the other DUT is held idle and expected to stay quiet.
  task automatic step(input int sel, input logic r, input logic en, input logic [4:0] a,
                      input logic sw, input string nm, input logic [31:0] eo,
                      input logic eb, input logic ed, input logic ee);
    exp_t x;
    exp_t idle;
    @(negedge clk);
    rst5 = 1'b0; if5.en = 1'b0; if5.addr = '0; if5.sweep_start = 1'b0;
    rst3 = 1'b0; if3.en = 1'b0; if3.addr = '0; if3.sweep_start = 1'b0;
    x    = '{cyc + 1, eo, eb, ed, ee, nm};
    idle = '{cyc + 1, 32'h0, 1'b0, 1'b0, 1'b0, "idle_other"};
    if (sel == 5) begin
      rst5 = r; if5.en = en; if5.addr = a; if5.sweep_start = sw;
      q5.push_back(x);
      q3.push_back(idle);
    end else begin
      rst3 = r; if3.en = en; if3.addr = a[2:0]; if3.sweep_start = sw;
      q3.push_back(x);
      q5.push_back(idle);
    end
  endtask

  initial begin
    logic en_j, sw_j;
    if5.en = 1'b0; if5.addr = '0; if5.sweep_start = 1'b0;
    if3.en = 1'b0; if3.addr = '0; if3.sweep_start = 1'b0;

    // Reset state and single decodes, one-hot with index 0 hardwired low
    step(5, 1'b1, 1'b0, 5'd0,  1'b0, "reset",      32'h0,         1'b0, 1'b0, 1'b0);
    step(5, 1'b0, 1'b1, 5'd13, 1'b0, "dec13",      32'h0000_2000, 1'b0, 1'b0, 1'b0);
    step(5, 1'b0, 1'b0, 5'd0,  1'b0, "dec13_clr",  32'h0,         1'b0, 1'b0, 1'b0);
    step(5, 1'b0, 1'b1, 5'd0,  1'b0, "dec0_skip",  32'h0,         1'b0, 1'b0, 1'b0);
    step(5, 1'b0, 1'b1, 5'd1,  1'b0, "b2b_1",      32'h0000_0002, 1'b0, 1'b0, 1'b0);
    step(5, 1'b0, 1'b1, 5'd31, 1'b0, "b2b_31",     32'h8000_0000, 1'b0, 1'b0, 1'b0);
    step(5, 1'b0, 1'b0, 5'd0,  1'b0, "idle",       32'h0,         1'b0, 1'b0, 1'b0);

    // Sweep with collision at start, drops mid-sweep, then done-cycle acceptance
    step(5, 1'b0, 1'b1, 5'd7, 1'b1, "sw_collide", 32'h0000_0002, 1'b1, 1'b0, 1'b1);
    for (int j = 1; j <= 30; j++) begin
      en_j = (j == 10) || (j == 15);
      sw_j = (j == 14);
      step(5, 1'b0, en_j, 5'd9, sw_j, "sweep", 32'd1 << (j + 1), 1'b1, 1'b0, en_j | sw_j);
    end
    step(5, 1'b0, 1'b0, 5'd0, 1'b0, "sweep_done",  32'h0,         1'b0, 1'b1, 1'b0);
    step(5, 1'b0, 1'b1, 5'd7, 1'b0, "done_accept", 32'h0000_0080, 1'b0, 1'b0, 1'b0);
    step(5, 1'b0, 1'b0, 5'd0, 1'b0, "idle",        32'h0,         1'b0, 1'b0, 1'b0);

    // Reset in the middle of a sweep: no done pulse afterwards
    step(5, 1'b0, 1'b0, 5'd0, 1'b1, "sw2_start", 32'h0000_0002, 1'b1, 1'b0, 1'b0);
    for (int j = 1; j <= 4; j++)
      step(5, 1'b0, 1'b0, 5'd0, 1'b0, "sw2", 32'd1 << (j + 1), 1'b1, 1'b0, 1'b0);
    step(5, 1'b1, 1'b0, 5'd0, 1'b0, "mid_reset",  32'h0,         1'b0, 1'b0, 1'b0);
    step(5, 1'b0, 1'b1, 5'd3, 1'b0, "post_reset", 32'h0000_0008, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 30; j++)
      step(5, 1'b0, 1'b0, 5'd0, 1'b0, "no_done", 32'h0, 1'b0, 1'b0, 1'b0);

    // Thermometer config, index 0 usable
    step(3, 1'b0, 1'b1, 5'd4, 1'b0, "th4",  32'h1F, 1'b0, 1'b0, 1'b0);
    step(3, 1'b0, 1'b1, 5'd0, 1'b0, "th0",  32'h01, 1'b0, 1'b0, 1'b0);
    step(3, 1'b0, 1'b1, 5'd7, 1'b0, "th7",  32'hFF, 1'b0, 1'b0, 1'b0);
    step(3, 1'b0, 1'b0, 5'd0, 1'b0, "idle", 32'h00, 1'b0, 1'b0, 1'b0);
    step(3, 1'b0, 1'b0, 5'd0, 1'b1, "th_sw", 32'h01, 1'b1, 1'b0, 1'b0);
    for (int j = 1; j <= 7; j++)
      step(3, 1'b0, 1'b0, 5'd0, 1'b0, "th_sweep", (32'd1 << (j + 1)) - 32'd1, 1'b1, 1'b0, 1'b0);
    step(3, 1'b0, 1'b0, 5'd0, 1'b0, "th_done", 32'h00, 1'b0, 1'b1, 1'b0);
    step(3, 1'b0, 1'b0, 5'd0, 1'b0, "idle",    32'h00, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    n_tests++;
    if (q5.size() + q3.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", q5.size() + q3.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/decoder_sweep.md
# decoder_sweep

Parametrised, registered address decoder: the next generation of the fixed 5-to-32 gate-level decoder. It turns an ADDR_W-bit address into a 2^ADDR_W-bit one-hot or thermometer select, and adds a sweep sequencer that walks every address one per cycle, used to clear the register file after boot or on an exception flush. It sits between writeback control and the register file write-enable lines.

## Interface
- ADDR_W, 5, address width; output width N = 2^ADDR_W.
- MODE, 0, 0 = one-hot output, 1 = thermometer output (out[i] = 1 for all i <= addr).
- SKIP_ZERO, 1, 1 = index 0 is never asserted (hardwired $zero); sweep starts at 1.
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  request a single decode of addr this cycle.
- addr  input  ADDR_W  address to decode when en is sampled.
- sweep_start  input  1  request a full sweep.
- out  output  N  registered select vector.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep completes.
- err  output  1  one-cycle pulse when a request was dropped.

## Operation
- States: IDLE, SWEEP. An internal counter cnt is ADDR_W bits wide.
- Reset: state = IDLE, cnt = 0, out = 0, busy = 0, done = 0, err = 0.
- IDLE, sweep_start = 1:
  - next state = SWEEP.
  - cnt loads FIRST, where FIRST = SKIP_ZERO ? 1 : 0.
  - out = decode(FIRST) on the next edge.
  - If en = 1 in the same cycle, sweep wins, the en request is dropped and err pulses.
- IDLE, en = 1 and sweep_start = 0: the next out = decode(addr).
  - With SKIP_ZERO = 1 and addr = 0, the next out = 0; this is legal and err does not pulse.
- IDLE, neither request: the next out = 0. Single decodes therefore produce one-cycle pulses.
- SWEEP:
  - Each cycle, out = decode(cnt+1) and cnt increments.
  - When cnt = N-1 is on out, the next cycle has state = IDLE, out = 0, busy = 0 and done = 1.
  - In MODE 1 the sweep output is a growing thermometer.
- SWEEP, requests:
  - en or sweep_start sampled while busy = 1 is ignored and err pulses in the next cycle.
  - A sweep is never restarted.
- Arithmetic: cnt compares against all-ones (N-1) for termination. cnt never wraps through 0 during a sweep.
- Reset mid-sweep: the next cycle has all outputs at 0 and state = IDLE. No done pulse is produced.

## Timing
- Single decode: latency is 1 cycle. en/addr sampled at edge t gives out valid during cycle t+1.
- Sweep timing:
  - sweep_start is sampled at edge t.
  - busy = 1 and out = decode(FIRST + k) during cycle t+1+k, for k = 0 .. N-1-FIRST.
  - done = 1 in cycle t+1+(N-FIRST).
- Handshake:
  - A request is accepted only when busy = 0.
  - A new en is accepted in the same cycle as done; back-to-back single decodes are accepted on every cycle.
- err:
  - Asserted in the cycle after the dropped request.
  - Back-to-back dropped requests keep err high.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package decoder_pkg holds:
  - MODE_ONEHOT = 0 and MODE_THERMO = 1.
  - The state enum {IDLE, SWEEP}.
- Sub-module decoder_comb: combinational and parametrised by ADDR_W and MODE. It is instantiated once, fed by a mux of addr and cnt+1 (FIRST on sweep entry). The SKIP_ZERO mask is applied before the output register.

## Test plan
- ADDR_W=5, MODE 0, SKIP_ZERO=1:
  - en, addr = 5'd13 at t -> out = 32'h0000_2000 at t+1 and 0 at t+2.
  - en, addr = 0 -> out = 0, err = 0.
- Sweep (same config): sweep_start at t -> out = 1<<k for k = 1..31 during t+1..t+31, busy high over the same cycles, done = 1 and out = 0 at t+32.
- Collision: sweep_start and en asserted together in IDLE -> sweep runs and err = 1 at t+1. en pulsed at t+10 -> err = 1 at t+11 and the sweep sequence is unchanged.
- Reset mid-sweep: reset at t+5 -> at t+6 out = 0, busy = 0, done never pulses. en, addr = 3 at t+6 -> out = 32'h8 at t+7.
- MODE 1, ADDR_W=3, SKIP_ZERO=0:
  - en, addr = 3'd4 -> out = 8'h1F.
  - Sweep -> out = 8'h01, 03, 07, …, FF over 8 cycles, then done.
- Done-cycle acceptance: en, addr = 7 sampled in the done cycle -> out = 1<<7 in the next cycle, err = 0.
